// File: rtl/lose_restart_ctrl_pkg.sv
// Shared game-state codes and lose_restart_ctrl sub-state encodings.
package lose_restart_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] GS_INITIAL   = 3'd0;
  localparam logic [STATE_W-1:0] GS_NEW_PIECE = 3'd1;
  localparam logic [STATE_W-1:0] GS_FALL      = 3'd2;
  localparam logic [STATE_W-1:0] GS_LOCK      = 3'd3;
  localparam logic [STATE_W-1:0] GS_CLEAR     = 3'd4;
  localparam logic [STATE_W-1:0] GS_LOSE      = 3'd5;

  typedef enum logic [2:0] {
    SUB_IDLE     = 3'd0,
    SUB_LOCKOUT  = 3'd1,
    SUB_WAIT_REL = 3'd2,
    SUB_ARMED    = 3'd3,
    SUB_HOLD     = 3'd4,
    SUB_REQ      = 3'd5
  } lr_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int timer_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lose_restart_ctrl_down_timer.sv
// Loadable countdown timer: clear beats load beats decrement; stops at zero, done = (count == 0).
// rst_n is active-high and synchronous; one-cycle registered update, no backpressure.
module down_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lose_restart_ctrl.sv
// Game-over handler: lockout, clean press-and-hold restart, blink strobe, saturating loss count.
// Registered request output; no backpressure. Optional auto-restart under LOSE_AUTO_RESTART_EN.
module lose_restart_ctrl
  import lose_restart_ctrl_pkg::*;
#(
  parameter int NUM_KEYS     = 2,
  parameter int LOCK_CYCLES  = 50_000_000,
  parameter int HOLD_CYCLES  = 5_000_000,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int CNT_W        = 8
`ifdef LOSE_AUTO_RESTART_EN
  ,
  parameter int AUTO_CYCLES  = 500_000_000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STATE_W-1:0]  game_current_state,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] key_mask,
  output logic [STATE_W-1:0]  game_next_state_lose,
  output logic                blink,
  output logic [CNT_W-1:0]    lose_count,
  output logic                busy
);

  localparam int LOCK_W  = timer_w(LOCK_CYCLES);
  localparam int HOLD_W  = timer_w(HOLD_CYCLES);
  localparam int BLINK_W = timer_w(BLINK_CYCLES);

  localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
  // The ARMED press cycle already counts as the first held cycle.
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  lr_state_e state_q, state_d;

  logic [NUM_KEYS-1:0] eff_key;
  logic                any_key;
  logic                in_lose;
  logic                timer_clr;
  logic                lock_load, lock_en, lock_done;
  logic                hold_load, hold_en, hold_clr, hold_done;
  logic                blink_load, blink_en, blink_done;
  logic [STATE_W-1:0]  next_state_q;

  assign eff_key = key_in & key_mask;
  assign any_key = |eff_key;
  assign in_lose = (game_current_state == GS_LOSE);

`ifdef LOSE_AUTO_RESTART_EN
  localparam int AUTO_W = timer_w(AUTO_CYCLES);
  localparam logic [AUTO_W-1:0] AUTO_LOAD = AUTO_W'(AUTO_CYCLES - 1);

  logic auto_load, auto_en, auto_done;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= SUB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_load = 1'b0;
    lock_en   = 1'b0;
    hold_load = 1'b0;
    hold_en   = 1'b0;
`ifdef LOSE_AUTO_RESTART_EN
    auto_load = 1'b0;
    auto_en   = 1'b0;
`endif
    case (state_q)
      SUB_IDLE: begin
        if (in_lose) begin
          state_d   = SUB_LOCKOUT;
          lock_load = 1'b1;
        end
      end
      SUB_LOCKOUT: begin
        if (lock_done) begin
          state_d = SUB_WAIT_REL;
`ifdef LOSE_AUTO_RESTART_EN
          auto_load = 1'b1;
`endif
        end else begin
          lock_en = 1'b1;
        end
      end
      SUB_WAIT_REL: begin
        if (!any_key) state_d = SUB_ARMED;
      end
      SUB_ARMED: begin
        if (any_key) begin
          if (HOLD_CYCLES == 1) begin
            state_d = SUB_REQ;
          end else begin
            state_d   = SUB_HOLD;
            hold_load = 1'b1;
          end
        end
      end
      SUB_HOLD: begin
        // A release wins over a same-cycle expiry: the hold was not long enough.
        if (!any_key) begin
          state_d = SUB_ARMED;
        end else if (hold_done) begin
          state_d = SUB_REQ;
        end else begin
          hold_en = 1'b1;
        end
      end
      SUB_REQ: begin
        state_d = SUB_REQ;
      end
      default: begin
        state_d = SUB_IDLE;
      end
    endcase

`ifdef LOSE_AUTO_RESTART_EN
    if ((state_q == SUB_WAIT_REL || state_q == SUB_ARMED || state_q == SUB_HOLD)
        && state_d != SUB_REQ) begin
      if (auto_done) state_d = SUB_REQ;
      else           auto_en = 1'b1;
    end
`endif

    // Leaving lose (including the normal REQ exit) always returns to IDLE.
    if (state_q != SUB_IDLE && !in_lose) begin
      state_d = SUB_IDLE;
    end
  end

  assign timer_clr  = (state_d == SUB_IDLE);
  assign hold_clr   = timer_clr || (state_q == SUB_HOLD && state_d == SUB_ARMED);
  assign blink_en   = (state_q != SUB_IDLE) && !timer_clr;
  assign blink_load = (state_q == SUB_IDLE && state_d == SUB_LOCKOUT) || (blink_en && blink_done);

  down_timer #(.W(LOCK_W)) u_lock_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .load     (lock_load),
    .load_val (LOCK_LOAD),
    .en       (lock_en),
    .done     (lock_done)
  );

  down_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (hold_clr),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .en       (hold_en),
    .done     (hold_done)
  );

  down_timer #(.W(BLINK_W)) u_blink_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .load     (blink_load),
    .load_val (BLINK_LOAD),
    .en       (blink_en),
    .done     (blink_done)
  );

`ifdef LOSE_AUTO_RESTART_EN
  down_timer #(.W(AUTO_W)) u_auto_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .load     (auto_load),
    .load_val (AUTO_LOAD),
    .en       (auto_en),
    .done     (auto_done)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      blink <= 1'b0;
    end else if (timer_clr) begin
      blink <= 1'b0;
    end else if (state_q == SUB_IDLE) begin
      blink <= 1'b1;
    end else if (blink_done) begin
      blink <= ~blink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      lose_count <= '0;
    end else if (state_q == SUB_IDLE && in_lose && lose_count != '1) begin
      lose_count <= lose_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      next_state_q <= GS_LOSE;
    end else begin
      next_state_q <= (state_d == SUB_REQ) ? GS_INITIAL : GS_LOSE;
    end
  end

  assign game_next_state_lose = next_state_q;
  assign busy                 = (state_q == SUB_LOCKOUT);

endmodule

// File: tb/tb_lose_restart_ctrl.sv
// Directed bench for lose_restart_ctrl: lockout, hold/restart, masking, abort, saturation, reset.
module tb_lose_restart_ctrl;
  import lose_restart_ctrl_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] gs;
  logic [1:0] key_in;
  logic [1:0] key_mask;
  logic [2:0] nxt;
  logic       blink;
  logic [7:0] cnt;
  logic       busy;

  logic       rst2;
  logic [2:0] gs2;
  logic [2:0] nxt2;
  logic       blink2;
  logic [1:0] cnt2;
  logic       busy2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  lose_restart_ctrl #(
    .NUM_KEYS(2), .LOCK_CYCLES(4), .HOLD_CYCLES(3), .BLINK_CYCLES(2), .CNT_W(8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .game_current_state   (gs),
    .key_in               (key_in),
    .key_mask             (key_mask),
    .game_next_state_lose (nxt),
    .blink                (blink),
    .lose_count           (cnt),
    .busy                 (busy)
  );

  lose_restart_ctrl #(
    .NUM_KEYS(2), .LOCK_CYCLES(4), .HOLD_CYCLES(3), .BLINK_CYCLES(2), .CNT_W(2)
  ) dut_sat (
    .clk                  (clk),
    .rst_n                (rst2),
    .game_current_state   (gs2),
    .key_in               (key_in),
    .key_mask             (key_mask),
    .game_next_state_lose (nxt2),
    .blink                (blink2),
    .lose_count           (cnt2),
    .busy                 (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_lose();
    gs = GS_LOSE;
    step();
    exp_cnt++;
    chk("enter_cnt", 32'(cnt), exp_cnt);
    chk("enter_busy", 32'(busy), 1);
    chk("enter_blink", 32'(blink), 1);
  endtask

  // Four lockout cycles plus one WAIT_REL cycle with keys released.
  task automatic to_armed();
    repeat (5) step();
    chk("armed_busy", 32'(busy), 0);
  endtask

  task automatic leave_lose();
    gs = GS_INITIAL;
    step();
    chk("leave_out", 32'(nxt), 32'(GS_LOSE));
    chk("leave_blink", 32'(blink), 0);
    chk("leave_busy", 32'(busy), 0);
  endtask

  initial begin
    rst_n    = 1'b1;
    rst2     = 1'b1;
    gs       = GS_INITIAL;
    gs2      = GS_INITIAL;
    key_in   = 2'b00;
    key_mask = 2'b11;
    repeat (3) step();
    chk("rst_out", 32'(nxt), 32'(GS_LOSE));
    chk("rst_blink", 32'(blink), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b0;
    rst2  = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Lose with no keys: 4 busy cycles, blink period 4, never a request.
    enter_lose();
    for (int k = 1; k <= 12; k++) begin
      chk("lock_busy", 32'(busy), 32'(k <= 4));
      chk("blink_pat", 32'(blink), 32'(((k - 1) / 2) % 2 == 0));
      chk("idle_out", 32'(nxt), 32'(GS_LOSE));
      step();
    end
    leave_lose();

    // Key held through lockout must be released before it counts.
    key_in = 2'b01;
    enter_lose();
    for (int i = 0; i < 10; i++) begin
      chk("held_out", 32'(nxt), 32'(GS_LOSE));
      step();
    end
    key_in = 2'b00;
    step();
    chk("rel_out", 32'(nxt), 32'(GS_LOSE));
    key_in = 2'b01;
    step();
    chk("rp1_out", 32'(nxt), 32'(GS_LOSE));
    step();
    chk("rp2_out", 32'(nxt), 32'(GS_LOSE));
    step();
    chk("rp3_init", 32'(nxt), 32'(GS_INITIAL));
    step();
    chk("req_hold", 32'(nxt), 32'(GS_INITIAL));
    leave_lose();
    key_in = 2'b00;

    // Short press aborts, full press requests.
    enter_lose();
    to_armed();
    key_in = 2'b01;
    step();
    chk("sp1_out", 32'(nxt), 32'(GS_LOSE));
    step();
    chk("sp2_out", 32'(nxt), 32'(GS_LOSE));
    key_in = 2'b00;
    step();
    chk("sp_rel", 32'(nxt), 32'(GS_LOSE));
    key_in = 2'b01;
    step();
    chk("lp1_out", 32'(nxt), 32'(GS_LOSE));
    step();
    chk("lp2_out", 32'(nxt), 32'(GS_LOSE));
    step();
    chk("lp3_init", 32'(nxt), 32'(GS_INITIAL));
    leave_lose();
    key_in = 2'b00;

    // Masked key is ignored; unmasked key restarts.
    key_mask = 2'b01;
    key_in   = 2'b10;
    enter_lose();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mask_out", 32'(nxt), 32'(GS_LOSE));
    end
    key_in = 2'b01;
    step();
    chk("mk1_out", 32'(nxt), 32'(GS_LOSE));
    step();
    chk("mk2_out", 32'(nxt), 32'(GS_LOSE));
    step();
    chk("mk3_init", 32'(nxt), 32'(GS_INITIAL));
    leave_lose();
    key_mask = 2'b11;
    key_in   = 2'b00;

    // Leaving lose mid-HOLD aborts to IDLE; re-entry starts a fresh lockout.
    enter_lose();
    to_armed();
    key_in = 2'b01;
    step();
    chk("hold_out", 32'(nxt), 32'(GS_LOSE));
    leave_lose();
    key_in = 2'b00;
    enter_lose();

    // Reset mid-HOLD clears everything including the count.
    to_armed();
    key_in = 2'b01;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_out", 32'(nxt), 32'(GS_LOSE));
    chk("mrst_blink", 32'(blink), 0);
    chk("mrst_cnt", 32'(cnt), 0);
    chk("mrst_busy", 32'(busy), 0);
    rst_n  = 1'b0;
    key_in = 2'b00;
    exp_cnt = 0;
    step();
    chk("post_rst_cnt", 32'(cnt), 1);
    chk("post_rst_busy", 32'(busy), 1);
    gs = GS_INITIAL;
    step();

    // Two-bit loss counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      gs2 = GS_LOSE;
      step();
      chk("sat_cnt", 32'(cnt2), (i < 3) ? i + 1 : 3);
      gs2 = GS_INITIAL;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
